// File: rtl/ro_puf_pkg.sv
// Shared types and default constants for the ring-oscillator PUF reader.
package ro_puf_pkg;

    localparam int CNT_W_DEF     = 12;
    localparam int SEL_W_DEF     = 4;
    localparam int RESP_BITS_DEF = 8;
    localparam int WINDOW_DEF    = 1024;
    localparam int SETTLE_DEF    = 2;

    // Measurement sequence; one CLEAR..COMPARE pass per response bit.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COUNT   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } puf_state_t;

endpackage

// File: rtl/ro_window_timer.sv
// Loadable 16-bit down-counter; o_zero marks the last cycle of a loaded span.
// Loading N-1 on a state-entry edge makes o_zero rise in the Nth cycle.
module ro_window_timer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [15:0] i_load_val,
    output logic        o_zero
);

    logic [15:0] r_count;

    // Count down to zero and park there until the next load.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 16'd0) begin
            r_count <= r_count - 16'd1;
        end
    end

    assign o_zero = (r_count == 16'd0);

endmodule

// File: rtl/ro_puf_reader.sv
// Ring-oscillator PUF measurement controller: for each response bit it
// clears the two edge counters, gates them for WINDOW cycles, waits SETTLE
// cycles, compares the counts and shifts the result into the response word.
module ro_puf_reader
    import ro_puf_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int RESP_BITS = RESP_BITS_DEF,
    parameter int WINDOW    = WINDOW_DEF,
    parameter int SETTLE    = SETTLE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [SEL_W-1:0]     i_challenge,
    output logic                 o_busy,
    output logic [SEL_W-1:0]     o_ro_sel_a,
    output logic [SEL_W-1:0]     o_ro_sel_b,
    output logic                 o_cnt_clear,
    output logic                 o_cnt_enable,
    input  logic [CNT_W-1:0]     i_cnt_a,
    input  logic [CNT_W-1:0]     i_cnt_b,
    output logic [RESP_BITS-1:0] o_resp,
    output logic                 o_resp_valid,
    input  logic                 i_resp_ready,
    output logic                 o_ovf,
    output logic                 o_tie
);

    localparam int          IDX_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [15:0] WIN_LOAD = 16'(WINDOW - 1);
    localparam logic [15:0] SET_LOAD = 16'(SETTLE - 1);

    puf_state_t             r_state;
    puf_state_t             w_next_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_inc;
    logic [IDX_W:0]         w_idx_x2;
    logic                   w_last;
    logic [SEL_W-1:0]       r_base;
    logic [SEL_W-1:0]       w_sel_a_next;
    logic                   w_timer_load;
    logic [15:0]            w_timer_val;
    logic                   w_timer_zero;

    logic                   r_busy;
    logic                   r_cnt_clear;
    logic                   r_cnt_enable;
    logic                   r_resp_valid;
    logic [SEL_W-1:0]       r_sel_a;
    logic [SEL_W-1:0]       r_sel_b;
    logic [RESP_BITS-1:0]   r_resp;
    logic                   r_ovf;
    logic                   r_tie;

    // One timer serves both the counting window and the settle gap.
    ro_window_timer u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_zero     (w_timer_zero)
    );

    assign w_last       = (r_idx == IDX_W'(RESP_BITS - 1));
    assign w_idx_inc    = r_idx + IDX_W'(1);
    assign w_idx_x2     = {w_idx_inc, 1'b0};
    // RO pair for the next bit: base + 2(i+1), wrapping modulo 2^SEL_W.
    assign w_sel_a_next = r_base + SEL_W'(w_idx_x2);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and timer loads for the measurement sequence.
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_timer_load = 1'b0;
        w_timer_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_next_state = ST_COUNT;
                w_timer_load = 1'b1;
                w_timer_val  = WIN_LOAD;
            end
            ST_COUNT: begin
                if (w_timer_zero) begin
                    w_next_state = ST_SETTLE;
                    w_timer_load = 1'b1;
                    w_timer_val  = SET_LOAD;
                end
            end
            ST_SETTLE: begin
                if (w_timer_zero) begin
                    w_next_state = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_next_state = w_last ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: begin
                if (r_resp_valid && i_resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs follow the state being entered; datapath captures
    // the challenge on accept and folds each comparison into the response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy       <= 1'b0;
            r_cnt_clear  <= 1'b0;
            r_cnt_enable <= 1'b0;
            r_resp_valid <= 1'b0;
            r_sel_a      <= '0;
            r_sel_b      <= '0;
            r_base       <= '0;
            r_idx        <= '0;
            r_resp       <= '0;
            r_ovf        <= 1'b0;
            r_tie        <= 1'b0;
        end else begin
            r_busy       <= (w_next_state != ST_IDLE);
            r_cnt_clear  <= (w_next_state == ST_CLEAR);
            r_cnt_enable <= (w_next_state == ST_COUNT);
            r_resp_valid <= (w_next_state == ST_DONE);

            if (r_state == ST_IDLE && i_start) begin
                r_base  <= i_challenge;
                r_idx   <= '0;
                r_sel_a <= i_challenge;
                r_sel_b <= i_challenge + SEL_W'(1);
                r_resp  <= '0;
                r_ovf   <= 1'b0;
                r_tie   <= 1'b0;
            end

            if (r_state == ST_COMPARE) begin
                // Equal counts fall out of '>' as 0, which is the tie value.
                r_resp[r_idx] <= (i_cnt_a > i_cnt_b);
                if (i_cnt_a == i_cnt_b) begin
                    r_tie <= 1'b1;
                end
                if (i_cnt_a == {CNT_W{1'b1}} || i_cnt_b == {CNT_W{1'b1}}) begin
                    r_ovf <= 1'b1;
                end
                if (!w_last) begin
                    r_idx   <= w_idx_inc;
                    r_sel_a <= w_sel_a_next;
                    r_sel_b <= w_sel_a_next + SEL_W'(1);
                end
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_cnt_clear  = r_cnt_clear;
    assign o_cnt_enable = r_cnt_enable;
    assign o_resp_valid = r_resp_valid;
    assign o_ro_sel_a   = r_sel_a;
    assign o_ro_sel_b   = r_sel_b;
    assign o_resp       = r_resp;
    assign o_ovf        = r_ovf;
    assign o_tie        = r_tie;

endmodule
